// File: rtl/max7219_rx.sv
// Receiver for the MAX7219 three-wire link: oversamples the serial lines, frames
// 16-bit words on LOAD and keeps a shadow copy of the MAX7219 register file.
module max7219_rx #(
  parameter int CLK_MIN_HALF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        max_din,
  input  logic        max_clk,
  input  logic        ce_,
  output logic [31:0] display_value,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data
);

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  // The transmitter guarantees the minimum max_clk half-period; nothing here checks it.
  logic unused_s;
  assign unused_s = (CLK_MIN_HALF > 0);

  logic [1:0]       din_sync_q, din_sync_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [2:0]       ce_sync_q, ce_sync_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      sr_q, sr_d;
  logic [7:0][7:0]  digit_q, digit_d;
  logic [7:0]       decode_q, decode_d;
  logic [3:0]       intensity_q, intensity_d;
  logic [2:0]       scan_q, scan_d;
  logic             shutdown_q, shutdown_d;
  logic             test_q, test_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [3:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;

  logic             ce_fall_s, ce_rise_s, clk_rise_s, ce_low_s;
  logic [3:0]       rx_addr_s;
  logic [7:0]       rx_data_s;
  logic [2:0]       rx_idx_s;

  function automatic logic [4:0] next_count(input logic [4:0] c);
    if (c >= CNT_SAT) begin
      return CNT_SAT;
    end else begin
      return c + 5'd1;
    end
  endfunction

  // Synchroniser shift chains; the third stage of clk/ce feeds the edge detectors.
  always_comb begin
    din_sync_d = {din_sync_q[0], max_din};
    clk_sync_d = {clk_sync_q[1:0], max_clk};
    ce_sync_d  = {ce_sync_q[1:0], ce_};
  end

  // Edge detection and frame field extraction.
  always_comb begin
    ce_low_s   = ~ce_sync_q[1];
    ce_fall_s  = ce_sync_q[2] & ~ce_sync_q[1];
    ce_rise_s  = ~ce_sync_q[2] & ce_sync_q[1];
    clk_rise_s = clk_sync_q[1] & ~clk_sync_q[2];
    rx_addr_s  = sr_q[11:8];
    rx_data_s  = sr_q[7:0];
    // addresses 1..8 map to digits 0..7; 3-bit wraparound turns 8 into 7
    rx_idx_s   = sr_q[10:8] - 3'd1;
  end

  // Frame assembly and register-file decode.
  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    digit_d     = digit_q;
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    shutdown_d  = shutdown_q;
    test_d      = test_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    if (ce_fall_s) begin
      cnt_d = 5'd0;
      sr_d  = 16'h0000;
    end else begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
    end

    // Shift after the clear so a coincident LOAD fall and clock rise leaves count 1.
    if (clk_rise_s && ce_low_s) begin
      sr_d  = {sr_d[14:0], din_sync_q[1]};
      cnt_d = next_count(cnt_d);
    end else begin
      sr_d  = sr_d;
      cnt_d = cnt_d;
    end

    if (ce_rise_s) begin
      if (cnt_q == CNT_FULL) begin
        valid_d = 1'b1;
        addr_d  = rx_addr_s;
        data_d  = rx_data_s;
        case (rx_addr_s)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit_d[rx_idx_s] = rx_data_s;
          4'h9:    decode_d    = rx_data_s;
          4'hA:    intensity_d = rx_data_s[3:0];
          4'hB:    scan_d      = rx_data_s[2:0];
          4'hC:    shutdown_d  = rx_data_s[0];
          4'hF:    test_d      = rx_data_s[0];
          default: decode_d    = decode_q;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State registers; LOAD synchroniser idles high so release does not fake a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_sync_q  <= 2'b00;
      clk_sync_q  <= 3'b000;
      ce_sync_q   <= 3'b111;
      cnt_q       <= 5'd0;
      sr_q        <= 16'h0000;
      digit_q     <= 64'h0;
      decode_q    <= 8'h00;
      intensity_q <= 4'h0;
      scan_q      <= 3'd0;
      shutdown_q  <= 1'b0;
      test_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 4'h0;
      data_q      <= 8'h00;
    end else begin
      din_sync_q  <= din_sync_d;
      clk_sync_q  <= clk_sync_d;
      ce_sync_q   <= ce_sync_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      digit_q     <= digit_d;
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      shutdown_q  <= shutdown_d;
      test_q      <= test_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Only the low nibble of each digit is visible.
  always_comb begin
    display_value = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      display_value[4*i +: 4] = digit_q[i][3:0];
    end
  end

  assign decode_mode  = decode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_q;
  assign shutdown_n   = shutdown_q;
  assign display_test = test_q;
  assign frame_valid  = valid_q;
  assign frame_err    = err_q;
  assign frame_addr   = addr_q;
  assign frame_data   = data_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Self-checking bench for max7219_rx: directed vector table, hand-written corner
// sequences and random frames against a register-file model.
module tb_max7219_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        max_din = 1'b0;
  logic        max_clk = 1'b0;
  logic        ce_ = 1'b1;
  logic [31:0] display_value;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;

  max7219_rx #(.CLK_MIN_HALF(2)) dut (
    .clk(clk), .rst_n(rst_n), .max_din(max_din), .max_clk(max_clk), .ce_(ce_),
    .display_value(display_value), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_addr(frame_addr), .frame_data(frame_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int nvalid = 0;
  int nerr = 0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) nvalid <= nvalid + 1;
    if (frame_err === 1'b1) nerr <= nerr + 1;
  end

  // Reference model: the MAX7219 register file plus the last accepted frame.
  logic [7:0] mregs [16];
  logic [3:0] m_addr;
  logic [7:0] m_data;

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    logic [31:0] disp;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        valid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    m_addr = 4'h0;
    m_data = 8'h00;
  endtask

  task automatic model_apply(input logic [16:0] bits, input int nbits);
    if (nbits == 16) begin
      mregs[bits[11:8]] = bits[7:0];
      m_addr = bits[11:8];
      m_data = bits[7:0];
    end
  endtask

  function automatic logic [31:0] model_disp();
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = mregs[i+1][3:0];
    return d;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".display"}, display_value, model_disp());
    chk({tag, ".decode"}, {24'h0, decode_mode}, {24'h0, mregs[9]});
    chk({tag, ".intensity"}, {28'h0, intensity}, {28'h0, mregs[10][3:0]});
    chk({tag, ".scan"}, {29'h0, scan_limit}, {29'h0, mregs[11][2:0]});
    chk({tag, ".shutdown"}, {31'h0, shutdown_n}, {31'h0, mregs[12][0]});
    chk({tag, ".test"}, {31'h0, display_test}, {31'h0, mregs[15][0]});
    chk({tag, ".addr"}, {28'h0, frame_addr}, {28'h0, m_addr});
    chk({tag, ".data"}, {24'h0, frame_data}, {24'h0, m_data});
  endtask

  // Drops LOAD and clocks out bits[nbits-1:0] MSB first, leaving LOAD low.
  task automatic send_bits(input logic [16:0] bits, input int nbits, input int half);
    ce_ = 1'b0;
    wait_cyc(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      max_din = bits[i];
      wait_cyc(half);
      max_clk = 1'b1;
      wait_cyc(half);
      max_clk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [16:0] bits, input int nbits, input int half);
    model_apply(bits, nbits);
    send_bits(bits, nbits, half);
    wait_cyc(half);
    ce_ = 1'b1;
    wait_cyc(6);
  endtask

  task automatic frame_checked(input string tag, input logic [16:0] bits,
                               input int nbits, input int half);
    int v0, e0;
    v0 = nvalid;
    e0 = nerr;
    do_frame(bits, nbits, half);
    chk({tag, ".valid_pulses"}, nvalid - v0, (nbits == 16) ? 1 : 0);
    chk({tag, ".err_pulses"}, nerr - e0, (nbits == 16) ? 0 : 1);
  endtask

  vec_t tbl [14];

  initial begin
    int v0, e0, half, r, nb;
    logic [16:0] bits;

    tbl[0]  = '{17'h00105, 16, 32'h00000005, 4'h1, 8'h05, 1'b1};
    tbl[1]  = '{17'h00108, 16, 32'h00000008, 4'h1, 8'h08, 1'b1};
    tbl[2]  = '{17'h00207, 16, 32'h00000078, 4'h2, 8'h07, 1'b1};
    tbl[3]  = '{17'h00306, 16, 32'h00000678, 4'h3, 8'h06, 1'b1};
    tbl[4]  = '{17'h00405, 16, 32'h00005678, 4'h4, 8'h05, 1'b1};
    tbl[5]  = '{17'h00504, 16, 32'h00045678, 4'h5, 8'h04, 1'b1};
    tbl[6]  = '{17'h00603, 16, 32'h00345678, 4'h6, 8'h03, 1'b1};
    tbl[7]  = '{17'h00702, 16, 32'h02345678, 4'h7, 8'h02, 1'b1};
    tbl[8]  = '{17'h00801, 16, 32'h12345678, 4'h8, 8'h01, 1'b1};
    tbl[9]  = '{17'h00109, 15, 32'h12345678, 4'h8, 8'h01, 1'b0};
    tbl[10] = '{17'h00109, 17, 32'h12345678, 4'h8, 8'h01, 1'b0};
    tbl[11] = '{17'h00000, 16, 32'h12345678, 4'h0, 8'h00, 1'b1};
    tbl[12] = '{17'h00D55, 16, 32'h12345678, 4'hD, 8'h55, 1'b1};
    tbl[13] = '{17'h00E12, 16, 32'h12345678, 4'hE, 8'h12, 1'b1};

    model_reset();
    #2 rst_n = 1'b0;
    wait_cyc(2);
    chk("reset.outputs", {display_value[15:0], decode_mode, intensity, scan_limit,
        shutdown_n, display_test, frame_valid, frame_err}, 32'h0);
    chk("reset.frame", {20'h0, frame_addr, frame_data}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      v0 = nvalid;
      e0 = nerr;
      do_frame(tbl[i].bits, tbl[i].nbits, 4);
      chk($sformatf("tbl%0d.display", i), display_value, tbl[i].disp);
      chk($sformatf("tbl%0d.addr", i), {28'h0, frame_addr}, {28'h0, tbl[i].addr});
      chk($sformatf("tbl%0d.data", i), {24'h0, frame_data}, {24'h0, tbl[i].data});
      chk($sformatf("tbl%0d.valid", i), nvalid - v0, tbl[i].valid ? 1 : 0);
      chk($sformatf("tbl%0d.err", i), nerr - e0, tbl[i].valid ? 0 : 1);
    end
    chk("tbl.ctrl_untouched", {decode_mode, intensity, scan_limit, shutdown_n, display_test},
        17'h0);

    // Control registers.
    do_frame(17'h00A07, 16, 3);
    do_frame(17'h00B05, 16, 3);
    do_frame(17'h00C01, 16, 3);
    do_frame(17'h009FF, 16, 3);
    do_frame(17'h00F01, 16, 3);
    chk("ctrl.intensity", {28'h0, intensity}, 32'h7);
    chk("ctrl.scan", {29'h0, scan_limit}, 32'h5);
    chk("ctrl.shutdown", {31'h0, shutdown_n}, 32'h1);
    chk("ctrl.decode", {24'h0, decode_mode}, 32'hFF);
    chk("ctrl.test", {31'h0, display_test}, 32'h1);
    do_frame(17'h0F0C1, 16, 3);
    chk("ctrl.upper_ignored", {20'h0, frame_addr, frame_data}, 32'h0C1);
    chk("ctrl.shutdown_kept", {31'h0, shutdown_n}, 32'h1);
    do_frame(17'h00C00, 16, 2);
    chk("ctrl.shutdown_off", {31'h0, shutdown_n}, 32'h0);

    // Latency: three clk edges from LOAD first sampled high to the update.
    model_apply(17'h00409, 16);
    send_bits(17'h00409, 16, 3);
    wait_cyc(3);
    ce_ = 1'b1;
    @(posedge clk); #1;
    chk("lat.edge_n", {display_value[31:1], frame_valid}, {31'h091A2B3C, 1'b0});
    @(posedge clk); #1;
    chk("lat.edge_n1", {display_value[31:1], frame_valid}, {31'h091A2B3C, 1'b0});
    @(posedge clk); #1;
    chk("lat.edge_n2", display_value, 32'h12349678);
    chk("lat.strobe_on", {31'h0, frame_valid}, 32'h1);
    @(posedge clk); #1;
    chk("lat.strobe_off", {31'h0, frame_valid}, 32'h0);
    wait_cyc(4);

    // Idle clocking with LOAD high changes nothing.
    v0 = nvalid;
    e0 = nerr;
    for (int i = 0; i < 20; i++) begin
      max_din = 1'($urandom);
      max_clk = 1'b1;
      wait_cyc(2);
      max_clk = 1'b0;
      wait_cyc(2);
    end
    wait_cyc(6);
    check_model("idle");
    chk("idle.strobes", (nvalid - v0) + (nerr - e0), 0);

    // Random frames against the model.
    for (int k = 0; k < 40; k++) begin
      half = $urandom_range(2, 5);
      r = $urandom_range(0, 4);
      nb = (r == 0) ? 15 : ((r == 4) ? 17 : 16);
      bits = 17'($urandom);
      frame_checked($sformatf("rnd%0d", k), bits, nb, half);
      check_model($sformatf("rnd%0d", k));
    end

    // Reset in the middle of a frame.
    v0 = nvalid;
    e0 = nerr;
    send_bits(17'h00002, 8, 3);
    rst_n = 1'b0;
    #1;
    chk("rstmid.display", display_value, 32'h0);
    chk("rstmid.ctrl", {decode_mode, intensity, scan_limit, shutdown_n, display_test,
        frame_valid, frame_err}, 19'h0);
    chk("rstmid.frame", {20'h0, frame_addr, frame_data}, 32'h0);
    wait_cyc(1);
    ce_ = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(6);
    chk("rstmid.no_strobe", (nvalid - v0) + (nerr - e0), 0);
    model_reset();
    frame_checked("post_rst", 17'h00203, 16, 3);
    chk("post_rst.display", display_value, 32'h00000030);
    check_model("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
